rx_lane_sync_ctrl: RTL and testbench

- Receive-lane synchronisation controller. Sits directly after the serial-to-parallel deserializer, in the clk_4f byte domain.
- Consumes the deserializer's byte stream (valid + 8-bit data) and sequences the lane through hunt, align and locked states using COM (0xBC) symbols.
- Forwards payload bytes only while locked and drops COM fill.
- Detects loss of sync from symbol errors or stream gaps and reports lock status and a loss counter to the link layer.

---
 rtl/pcie_phy_pkg.sv | 22 ++
 rtl/rx_lane_sync_ctrl_if.sv | 18 +
 rtl/rx_lane_sync_ctrl_sat.sv | 28 ++
 rtl/rx_lane_sync_ctrl.sv | 157 +++++++++++++++
 tb/tb_rx_lane_sync_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions: comma symbol and lane-sync FSM state encoding.
// Also used by the transmit-side idle-insertion logic.
package pcie_phy_pkg;

    localparam logic [7:0] COM_SYM_DEFAULT = 8'hBC;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_ALIGN   = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_RECOVER = 3'd4
    } lane_state_e;

    function automatic logic is_clean_com(input logic       valid,
                                          input logic       err,
                                          input logic [7:0] data,
                                          input logic [7:0] com);
        return valid && !err && (data == com);
    endfunction

endpackage

// File: rtl/rx_lane_sync_ctrl_if.sv
// Byte stream from the deserializer and the payload stream to the link layer.
interface rx_lane_sync_ctrl_if;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       byte_err;
    logic       data_valid_out;
    logic [7:0] data_out;

    modport master (
        output byte_valid, byte_in, byte_err,
        input  data_valid_out, data_out
    );

    modport slave (
        input  byte_valid, byte_in, byte_err,
        output data_valid_out, data_out
    );
endinterface

// File: rtl/rx_lane_sync_ctrl_sat.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_sat
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_sat   = &r_count;

endmodule

// File: rtl/rx_lane_sync_ctrl.sv
// Receive-lane sync controller: hunts for COM symbols, locks the lane, forwards
// payload while locked and reports loss of sync from errors or stream gaps.
module rx_lane_sync_ctrl
    import pcie_phy_pkg::*;
#(
    parameter logic [7:0]  COM_SYM     = COM_SYM_DEFAULT,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned ERR_LIMIT   = 3,
    parameter int unsigned GAP_TIMEOUT = 16
) (
    input  logic                 clk_4f,
    input  logic                 reset,
    input  logic                 enable,
    rx_lane_sync_ctrl_if.slave   lane,
    output logic                 sync_locked,
    output logic                 sync_lost,
    output logic [7:0]           loss_count,
    output logic [2:0]           state_out
);

    lane_state_e r_state;
    logic [3:0]  r_com_cnt;
    logic [3:0]  r_err_cnt;
    logic        r_data_valid;
    logic [7:0]  r_data;
    logic        r_sync_locked;
    logic        r_sync_lost;

    logic        w_clean_com;
    logic        w_in_locked;
    logic        w_err_trip;
    logic        w_gap_inc;
    logic        w_gap_clr;
    logic        w_gap_trip;
    logic        w_gap_sat;
    logic [7:0]  w_gap_cnt;
    logic        w_loss;
    logic        w_loss_sat;
    logic [7:0]  w_loss_cnt;

    assign w_clean_com = is_clean_com(lane.byte_valid, lane.byte_err, lane.byte_in, COM_SYM);
    assign w_in_locked = enable && (r_state == ST_LOCKED);

    // Errors only accumulate on consecutive errored bytes; idle cycles leave the count alone.
    assign w_err_trip = w_in_locked && lane.byte_valid && lane.byte_err &&
                        (({1'b0, r_err_cnt} + 5'd1) == 5'(ERR_LIMIT));

    assign w_gap_inc  = w_in_locked && !lane.byte_valid;
    assign w_gap_trip = w_gap_inc && (({1'b0, w_gap_cnt} + 9'd1) == 9'(GAP_TIMEOUT));
    assign w_gap_clr  = !w_gap_inc || w_gap_trip;
    assign w_loss     = w_err_trip || w_gap_trip;

    sat_counter #(.WIDTH(8)) u_gap_cnt (
        .clk     (clk_4f),
        .rst_n   (reset),
        .i_inc   (w_gap_inc && !w_gap_sat),
        .i_clr   (w_gap_clr),
        .o_count (w_gap_cnt),
        .o_sat   (w_gap_sat)
    );

    sat_counter #(.WIDTH(8)) u_loss_cnt (
        .clk     (clk_4f),
        .rst_n   (reset),
        .i_inc   (w_loss && !w_loss_sat),
        .i_clr   (1'b0),
        .o_count (w_loss_cnt),
        .o_sat   (w_loss_sat)
    );

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_com_cnt     <= '0;
            r_err_cnt     <= '0;
            r_data_valid  <= 1'b0;
            r_data        <= '0;
            r_sync_locked <= 1'b0;
            r_sync_lost   <= 1'b0;
        end else if (!enable) begin
            r_state       <= ST_IDLE;
            r_com_cnt     <= '0;
            r_err_cnt     <= '0;
            r_data_valid  <= 1'b0;
            r_data        <= '0;
            r_sync_locked <= 1'b0;
            r_sync_lost   <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_sync_lost  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_HUNT;
                end
                ST_HUNT: begin
                    if (w_clean_com) begin
                        if (LOCK_COUNT == 1) begin
                            r_state       <= ST_LOCKED;
                            r_sync_locked <= 1'b1;
                            r_com_cnt     <= '0;
                        end else begin
                            r_state   <= ST_ALIGN;
                            r_com_cnt <= 4'd1;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (lane.byte_valid) begin
                        if (!w_clean_com) begin
                            r_state   <= ST_HUNT;
                            r_com_cnt <= '0;
                        end else if (({1'b0, r_com_cnt} + 5'd1) == 5'(LOCK_COUNT)) begin
                            r_state       <= ST_LOCKED;
                            r_sync_locked <= 1'b1;
                            r_com_cnt     <= '0;
                        end else begin
                            r_com_cnt <= r_com_cnt + 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_loss) begin
                        r_state       <= ST_RECOVER;
                        r_sync_lost   <= 1'b1;
                        r_sync_locked <= 1'b0;
                        r_err_cnt     <= '0;
                    end else if (lane.byte_valid && !lane.byte_err) begin
                        r_err_cnt <= '0;
                        if (lane.byte_in != COM_SYM) begin
                            r_data       <= lane.byte_in;
                            r_data_valid <= 1'b1;
                        end
                    end else if (lane.byte_valid) begin
                        r_err_cnt <= r_err_cnt + 4'd1;
                    end
                end
                ST_RECOVER: begin
                    r_state   <= ST_HUNT;
                    r_com_cnt <= '0;
                    r_err_cnt <= '0;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_sync_locked <= 1'b0;
                end
            endcase
        end
    end

    assign lane.data_valid_out = r_data_valid;
    assign lane.data_out       = r_data;
    assign sync_locked         = r_sync_locked;
    assign sync_lost           = r_sync_lost;
    assign loss_count          = w_loss_cnt;
    assign state_out           = r_state;

endmodule

// File: tb/tb_rx_lane_sync_ctrl.sv
// Self-checking bench for rx_lane_sync_ctrl: directed scenarios plus random
// traffic compared cycle-by-cycle against a behavioural lane model.
module tb_rx_lane_sync_ctrl;

    localparam int COM      = 8'hBC;
    localparam int LOCK_N   = 4;
    localparam int ERR_N    = 3;
    localparam int GAP_N    = 16;
    localparam int S_IDLE   = 0;
    localparam int S_HUNT   = 1;
    localparam int S_ALIGN  = 2;
    localparam int S_LOCKED = 3;
    localparam int S_RECOV  = 4;

    logic       clk_4f;
    logic       reset;
    logic       enable;
    logic       sync_locked;
    logic       sync_lost;
    logic [7:0] loss_count;
    logic [2:0] state_out;

    rx_lane_sync_ctrl_if lane_if ();

    rx_lane_sync_ctrl dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .enable      (enable),
        .lane        (lane_if),
        .sync_locked (sync_locked),
        .sync_lost   (sync_lost),
        .loss_count  (loss_count),
        .state_out   (state_out)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks the lane phase and run lengths of COMs, errors and gaps.
    int   m_state;
    int   m_com_run;
    int   m_err_run;
    int   m_gap_run;
    int   m_loss;
    bit   m_dv;
    bit   m_lost;
    int   m_dout;

    task automatic model_reset();
        m_state = S_IDLE; m_com_run = 0; m_err_run = 0; m_gap_run = 0;
        m_loss = 0; m_dv = 0; m_lost = 0; m_dout = 0;
    endtask

    task automatic model_step(input bit en, input bit v, input int b, input bit e);
        bit clean_com;
        clean_com = v && !e && (b == COM);
        m_dv   = 0;
        m_lost = 0;
        if (!en) begin
            m_state = S_IDLE; m_dout = 0;
            m_com_run = 0; m_err_run = 0; m_gap_run = 0;
        end else if (m_state == S_IDLE) begin
            m_state = S_HUNT;
        end else if (m_state == S_HUNT || m_state == S_ALIGN) begin
            if (clean_com) begin
                m_com_run = (m_state == S_HUNT) ? 1 : m_com_run + 1;
                m_state = (m_com_run >= LOCK_N) ? S_LOCKED : S_ALIGN;
                if (m_state == S_LOCKED) m_com_run = 0;
            end else if (v && m_state == S_ALIGN) begin
                m_state = S_HUNT; m_com_run = 0;
            end
        end else if (m_state == S_LOCKED) begin
            if (v && !e) begin
                m_err_run = 0; m_gap_run = 0;
                if (b != COM) begin m_dv = 1; m_dout = b; end
            end else if (v) begin
                m_gap_run = 0;
                m_err_run++;
            end else begin
                m_gap_run++;
            end
            if (m_err_run >= ERR_N || m_gap_run >= GAP_N) begin
                m_state = S_RECOV; m_lost = 1;
                m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                m_err_run = 0; m_gap_run = 0;
            end
        end else begin
            m_state = S_HUNT; m_com_run = 0; m_err_run = 0; m_gap_run = 0;
        end
    endtask

    task automatic compare_all();
        check("state",  32'(state_out),             32'(m_state));
        check("locked", 32'(sync_locked),           32'(m_state == S_LOCKED));
        check("lost",   32'(sync_lost),             32'(m_lost));
        check("dv",     32'(lane_if.data_valid_out), 32'(m_dv));
        check("dout",   32'(lane_if.data_out),      32'(m_dout));
        check("loss",   32'(loss_count),            32'(m_loss));
    endtask

    task automatic drive(input bit en, input bit v, input int b, input bit e);
        enable             = en;
        lane_if.byte_valid = v;
        lane_if.byte_in    = 8'(b);
        lane_if.byte_err   = e;
        @(posedge clk_4f);
        model_step(en, v, b, e);
        #1;
        compare_all();
    endtask

    task automatic send(input int b);   drive(1, 1, b, 0); endtask
    task automatic send_err();          drive(1, 1, 8'hE7, 1); endtask
    task automatic gap(input int n);    for (int i = 0; i < n; i++) drive(1, 0, 0, 0); endtask

    initial begin
        reset = 1'b0; enable = 1'b0;
        lane_if.byte_valid = 1'b0; lane_if.byte_in = 8'h00; lane_if.byte_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_4f);
        #1;
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_dv",    32'(lane_if.data_valid_out), 32'd0);
        check("rst_loss",  32'(loss_count), 32'd0);
        reset = 1'b1;

        // Lock acquisition then first payload byte
        drive(1, 0, 0, 0);
        for (int i = 0; i < LOCK_N; i++) send(COM);
        check("lock_rise",  32'(sync_locked), 32'd1);
        check("lock_state", 32'(state_out),   32'd3);
        send(8'h5A);
        check("first_dv",   32'(lane_if.data_valid_out), 32'd1);
        check("first_data", 32'(lane_if.data_out),       32'h5A);
        send(COM);
        check("com_nodv",   32'(lane_if.data_valid_out), 32'd0);
        send(8'h77); send(COM); send(8'h01);
        check("mixed_data", 32'(lane_if.data_out), 32'h01);

        // Errors interrupted by a clean byte do not lose sync
        send_err(); send_err(); send(8'h22);
        send_err(); send_err();
        check("no_loss", 32'(loss_count), 32'd0);
        send_err();
        check("err_recover", 32'(state_out), 32'd4);
        check("err_lost",    32'(sync_lost), 32'd1);
        check("err_cnt1",    32'(loss_count), 32'd1);
        drive(1, 1, COM, 0);
        check("err_hunt",    32'(state_out), 32'd1);
        check("err_pulse",   32'(sync_lost), 32'd0);

        // Gap timeout boundary
        for (int i = 0; i < LOCK_N; i++) send(COM);
        gap(GAP_N - 1);
        send(8'h33);
        check("gap15_lock", 32'(state_out), 32'd3);
        check("gap15_data", 32'(lane_if.data_out), 32'h33);
        gap(GAP_N);
        check("gap16_state", 32'(state_out), 32'd4);
        check("gap16_lost",  32'(sync_lost), 32'd1);
        check("gap16_cnt",   32'(loss_count), 32'd2);
        gap(1);

        // Broken alignment
        send(COM); send(COM); send(8'h11);
        check("broken_hunt", 32'(state_out), 32'd1);
        check("broken_dv",   32'(lane_if.data_valid_out), 32'd0);
        for (int i = 0; i < LOCK_N - 1; i++) send(COM);
        check("realign", 32'(state_out), 32'd2);
        send(COM);
        check("relock",  32'(state_out), 32'd3);

        // Disable while locked
        send(8'h44);
        drive(0, 1, 8'h55, 0);
        check("dis_state", 32'(state_out), 32'd0);
        check("dis_dv",    32'(lane_if.data_valid_out), 32'd0);
        check("dis_lock",  32'(sync_locked), 32'd0);
        check("dis_loss",  32'(loss_count), 32'd2);

        // Asynchronous reset while aligning
        drive(1, 0, 0, 0); send(COM); send(COM);
        check("pre_rst_align", 32'(state_out), 32'd2);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("arst_state", 32'(state_out), 32'd0);
        check("arst_loss",  32'(loss_count), 32'd0);
        check("arst_dv",    32'(lane_if.data_valid_out), 32'd0);
        #3 reset = 1'b1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                gap($urandom_range(GAP_N - 2, GAP_N + 1));
            end else begin
                drive($urandom_range(0, 99) >= 2,
                      $urandom_range(0, 99) < 80,
                      ($urandom_range(0, 99) < 55) ? COM : int'($urandom_range(0, 255)),
                      $urandom_range(0, 99) < 6);
            end
        end

        // Loss counter saturation
        drive(0, 0, 0, 0);
        for (int n = 0; n < 260; n++) begin
            drive(1, 0, 0, 0);
            for (int i = 0; i < LOCK_N; i++) send(COM);
            for (int i = 0; i < ERR_N; i++) send_err();
        end
        check("sat_255", 32'(loss_count), 32'd255);
        drive(1, 0, 0, 0);
        for (int i = 0; i < LOCK_N; i++) send(COM);
        for (int i = 0; i < ERR_N; i++) send_err();
        check("sat_hold", 32'(loss_count), 32'd255);
        check("sat_lost", 32'(sync_lost),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
